mb_rx_deser_multilane: RTL and testbench

//  Parametrised mainband RX deserializer. Captures NUM_LANES serial data lanes in parallel,

---
 rtl/mb_rx_deser_multilane_if.sv | 27 ++
 rtl/mb_rx_deser_multilane.sv | 91 +++++++++
 tb/tb_mb_rx_deser_multilane.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mb_rx_deser_multilane_if.sv
// Bus bundle for the multilane mainband RX deserializer: serial capture inputs,
// consumer handshake and the assembled word outputs.
interface mb_rx_deser_multilane_if #(
    parameter int NUM_LANES = 16,
    parameter int DATA_W    = 32
);
    localparam int CNT_W = $clog2(DATA_W);

    logic [NUM_LANES-1:0]        i_ser_data;
    logic                        i_ser_vld;
    logic                        i_realign;
    logic                        i_ready;
    logic [NUM_LANES*DATA_W-1:0] o_data;
    logic                        o_valid;
    logic                        o_overrun;
    logic [CNT_W-1:0]            o_bit_cnt;

    modport master (
        output i_ser_data, i_ser_vld, i_realign, i_ready,
        input  o_data, o_valid, o_overrun, o_bit_cnt
    );

    modport slave (
        input  i_ser_data, i_ser_vld, i_realign, i_ready,
        output o_data, o_valid, o_overrun, o_bit_cnt
    );
endinterface

// File: rtl/mb_rx_deser_multilane.sv
// Mainband RX deserializer: shifts NUM_LANES serial lanes into DATA_W-bit words
// on a shared UI counter and presents them through a one-entry valid/ready register.
module mb_rx_deser_multilane #(
    parameter int NUM_LANES = 16,
    parameter int DATA_W    = 32,
    parameter int MSB_FIRST = 0
) (
    input logic                     i_clk,
    input logic                     i_rst,
    mb_rx_deser_multilane_if.slave  bus
);
    localparam int               CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(DATA_W - 1);

    typedef enum logic {ST_EMPTY, ST_FULL} state_e;

    state_e                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [DATA_W-1:0]           shift_q [NUM_LANES];
    logic [DATA_W-1:0]           shift_d [NUM_LANES];
    logic [NUM_LANES*DATA_W-1:0] word;
    logic [NUM_LANES*DATA_W-1:0] data_q, data_d;
    logic                        ovr_q, ovr_d;
    logic                        complete;

    // The shifted value doubles as the completed word when the last UI arrives.
    always_comb begin : capture
        complete = bus.i_ser_vld && !bus.i_realign && (cnt_q == LAST);
        cnt_d    = cnt_q;
        word     = '0;
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
            shift_d[l] = shift_q[l];
            if (MSB_FIRST != 0)
                word[l*DATA_W +: DATA_W] = {shift_q[l][DATA_W-2:0], bus.i_ser_data[l]};
            else
                word[l*DATA_W +: DATA_W] = {bus.i_ser_data[l], shift_q[l][DATA_W-1:1]};
            if (bus.i_realign)
                shift_d[l] = '0;
            else if (bus.i_ser_vld)
                shift_d[l] = word[l*DATA_W +: DATA_W];
        end
        if (bus.i_realign)
            cnt_d = '0;
        else if (bus.i_ser_vld)
            cnt_d = complete ? '0 : cnt_q + 1'b1;
    end

    always_comb begin : out_fsm
        state_d = state_q;
        data_d  = data_q;
        ovr_d   = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (complete) begin
                    state_d = ST_FULL;
                    data_d  = word;
                end
            end
            ST_FULL: begin
                if (bus.i_ready) begin
                    if (complete) data_d  = word;
                    else          state_d = ST_EMPTY;
                end else if (complete) begin
                    ovr_d = 1'b1;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_EMPTY;
            cnt_q   <= '0;
            shift_q <= '{default: '0};
            data_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.o_data    = data_q;
    assign bus.o_valid   = (state_q == ST_FULL);
    assign bus.o_overrun = ovr_q;
    assign bus.o_bit_cnt = cnt_q;
endmodule

// File: tb/tb_mb_rx_deser_multilane.sv
// Bench for mb_rx_deser_multilane: LSB-first and MSB-first instances share stimulus
// and are compared every cycle against a bit-position reference model.
module tb_mb_rx_deser_multilane;
    localparam int NL = 16;
    localparam int DW = 32;
    localparam int CW = $clog2(DW);
    localparam int OW = NL * DW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mb_rx_deser_multilane_if #(.NUM_LANES(NL), .DATA_W(DW)) ifa ();
    mb_rx_deser_multilane_if #(.NUM_LANES(NL), .DATA_W(DW)) ifb ();

    mb_rx_deser_multilane #(.NUM_LANES(NL), .DATA_W(DW), .MSB_FIRST(0)) dut_a (
        .i_clk(clk), .i_rst(rst), .bus(ifa.slave));
    mb_rx_deser_multilane #(.NUM_LANES(NL), .DATA_W(DW), .MSB_FIRST(1)) dut_b (
        .i_clk(clk), .i_rst(rst), .bus(ifb.slave));

    logic [NL-1:0] sd;
    logic          vld, rea, rdy;
    int            ntests = 0, nfail = 0;

    // Reference state: bit k of the current word is held by UI index k.
    int unsigned   k_m;
    logic [DW-1:0] part_l [NL];
    logic [DW-1:0] part_m [NL];
    logic          mv_a, mv_b, mo_a, mo_b;
    logic [OW-1:0] md_a, md_b;

    int            cyc = 0, vcnt = 0, ocnt = 0, last_v = 0, gap_err = 0;

    task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic out_model(inout logic v, inout logic [OW-1:0] d, output logic o,
                             input logic cpl, input logic [OW-1:0] w);
        o = 1'b0;
        if (cpl) begin
            if (!v || rdy) begin v = 1'b1; d = w; end
            else o = 1'b1;
        end else if (v && rdy) begin
            v = 1'b0;
        end
    endtask

    task automatic step();
        logic          cpl;
        logic [OW-1:0] wl, wm;
        cpl = 1'b0;
        wl  = '0;
        wm  = '0;
        @(posedge clk);
        if (rst) begin
            k_m = 0;
            for (int l = 0; l < NL; l++) begin part_l[l] = '0; part_m[l] = '0; end
            mv_a = 0; mv_b = 0; mo_a = 0; mo_b = 0; md_a = '0; md_b = '0;
        end else begin
            if (rea) begin
                k_m = 0;
                for (int l = 0; l < NL; l++) begin part_l[l] = '0; part_m[l] = '0; end
            end else if (vld) begin
                for (int l = 0; l < NL; l++) begin
                    part_l[l][k_m]        = sd[l];
                    part_m[l][DW-1-k_m]   = sd[l];
                end
                if (k_m == DW - 1) begin
                    cpl = 1'b1;
                    k_m = 0;
                    for (int l = 0; l < NL; l++) begin
                        wl[l*DW +: DW] = part_l[l];
                        wm[l*DW +: DW] = part_m[l];
                        part_l[l] = '0;
                        part_m[l] = '0;
                    end
                end else begin
                    k_m++;
                end
            end
            out_model(mv_a, md_a, mo_a, cpl, wl);
            out_model(mv_b, md_b, mo_b, cpl, wm);
        end
        #1;
        cyc++;
        chk("a_valid",   OW'(ifa.o_valid),   OW'(mv_a));
        chk("a_data",    ifa.o_data,         md_a);
        chk("a_overrun", OW'(ifa.o_overrun), OW'(mo_a));
        chk("a_bit_cnt", OW'(ifa.o_bit_cnt), OW'(k_m));
        chk("b_valid",   OW'(ifb.o_valid),   OW'(mv_b));
        chk("b_data",    ifb.o_data,         md_b);
        chk("b_overrun", OW'(ifb.o_overrun), OW'(mo_b));
        chk("b_bit_cnt", OW'(ifb.o_bit_cnt), OW'(k_m));
        if (ifa.o_valid) begin
            if (vcnt > 0 && cyc - last_v != DW) gap_err++;
            vcnt++;
            last_v = cyc;
        end
        if (ifa.o_overrun) ocnt++;
    endtask

    task automatic ui(input logic v, input logic [NL-1:0] d);
        vld = v; sd = d;
        ifa.i_ser_vld = vld; ifa.i_ser_data = sd; ifa.i_realign = rea; ifa.i_ready = rdy;
        ifb.i_ser_vld = vld; ifb.i_ser_data = sd; ifb.i_realign = rea; ifb.i_ready = rdy;
        step();
    endtask

    // Lane 0 carries w, lane 1 carries ~w (first UI = bit 0); other lanes random.
    task automatic send_word(input logic [DW-1:0] w, input logic [DW-1:0] gaps);
        logic [NL-1:0] d;
        for (int k = 0; k < DW; k++) begin
            d    = NL'($urandom);
            d[0] = w[k];
            d[1] = ~w[k];
            ui(1'b1, d);
            if (gaps[k]) repeat (5) ui(1'b0, NL'($urandom));
        end
    endtask

    initial begin
        rst = 1'b1; rea = 1'b0; rdy = 1'b1; vld = 1'b0; sd = '0;
        // T1 reset with random serial input
        repeat (3) ui(1'(($urandom)), NL'($urandom));
        chk("t1_valid", OW'(ifa.o_valid), '0);
        chk("t1_data",  ifa.o_data, '0);
        chk("t1_cnt",   OW'(ifa.o_bit_cnt), '0);
        rst = 1'b0;
        ui(1'b0, '0);

        // T2 single word
        send_word(32'hA5A5_0F0F, '0);
        chk("t2_valid", OW'(ifa.o_valid), OW'(1));
        chk("t2_lane0", OW'(ifa.o_data[31:0]),  OW'(32'hA5A5_0F0F));
        chk("t2_lane1", OW'(ifa.o_data[63:32]), OW'(32'h5A5A_F0F0));
        repeat (3) ui(1'b0, NL'($urandom));

        // T3 gaps after UIs 3, 17, 31
        send_word(32'hA5A5_0F0F, (32'd1 << 2) | (32'd1 << 16) | (32'd1 << 30));
        chk("t3_lane0", OW'(ifa.o_data[31:0]),  OW'(32'hA5A5_0F0F));
        chk("t3_lane1", OW'(ifa.o_data[63:32]), OW'(32'h5A5A_F0F0));
        ui(1'b0, '0);

        // T4 back-to-back, consumer always ready
        vcnt = 0; ocnt = 0; gap_err = 0;
        send_word(32'h0000_0000, '0);
        send_word(32'hFFFF_FFFF, '0);
        send_word(32'h1234_5678, '0);
        send_word(32'h8000_0001, '0);
        ui(1'b0, '0);
        chk("t4_vcnt",    OW'(vcnt),    OW'(4));
        chk("t4_spacing", OW'(gap_err), '0);
        chk("t4_ovr",     OW'(ocnt),    '0);

        // T5 overrun while consumer stalls
        rdy = 1'b0; ocnt = 0;
        send_word(32'hDEAD_BEEF, '0);
        send_word(32'h0BAD_F00D, '0);
        repeat (2) ui(1'b0, '0);
        chk("t5_ovr",   OW'(ocnt), OW'(1));
        chk("t5_held",  OW'(ifa.o_data[31:0]), OW'(32'hDEAD_BEEF));
        chk("t5_valid", OW'(ifa.o_valid), OW'(1));
        rdy = 1'b1;
        ui(1'b0, '0);
        chk("t5_drain", OW'(ifa.o_valid), '0);

        // T6 realign mid-word, both bit orders
        for (int k = 0; k < 13; k++) ui(1'b1, NL'($urandom));
        chk("t6_cnt13", OW'(ifa.o_bit_cnt), OW'(13));
        rea = 1'b1;
        ui(1'b1, NL'($urandom));
        rea = 1'b0;
        chk("t6_cnt0", OW'(ifa.o_bit_cnt), '0);
        send_word(32'h0000_0005, '0);
        chk("t6_lsb", OW'(ifa.o_data[31:0]), OW'(32'h0000_0005));
        send_word(32'h0000_0001, '0);
        chk("t6_a1",  OW'(ifa.o_data[31:0]), OW'(32'h0000_0001));
        chk("t6_msb", OW'(ifb.o_data[31:0]), OW'(32'h8000_0000));
        ui(1'b0, '0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            rdy = ($urandom_range(99) < 50);
            rea = ($urandom_range(99) < 2);
            rst = ($urandom_range(999) < 5);
            ui($urandom_range(99) < 70, NL'($urandom));
        end
        rst = 1'b0; rea = 1'b0;
        ui(1'b0, '0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
